// File: rtl/tb_cmd_executor.sv
// Command executor behind the file-driven sequencer: latches one command line, decodes it,
// then drives set slots, waits on clocks/edges or checks observed slots, and acks completion.
module tb_cmd_executor #(
    parameter int NB_SET         = 8,
    parameter int NB_WAIT        = 8,
    parameter int NB_CHK         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ARG_CHARS      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5*8*ARG_CHARS-1:0]    args,
    input  logic                        args_valid,
    output logic                        ack,
    output logic                        busy,
    output logic [NB_SET*DATA_W-1:0]    set_o,
    input  logic [NB_WAIT-1:0]          wait_i,
    input  logic [NB_CHK*DATA_W-1:0]    chk_i,
    output logic                        timeout_o,
    output logic [15:0]                 err_cnt,
    output logic [2:0]                  state_dbg
);
    // Handshake: args is taken only on an args_valid cycle while IDLE; the command owns the
    // block until the one-cycle ack, and a strobe arriving while busy is dropped and counted.
    localparam int AW = 8 * ARG_CHARS;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT_CNT, S_WAIT_EDGE, S_ACK} state_t;
    typedef enum logic [2:0] {K_BAD, K_SET, K_CHK, K_WCLK, K_WTR, K_WTF, K_END} kind_t;
    typedef struct packed {
        logic        ok;
        logic [31:0] val;
    } num_t;

    localparam logic [63:0] KW_SET  = 64'("SET");
    localparam logic [63:0] KW_CHK  = 64'("CHK");
    localparam logic [63:0] KW_WCLK = 64'("WAIT_CLK");
    localparam logic [63:0] KW_WTR  = 64'("WTR");
    localparam logic [63:0] KW_WTF  = 64'("WTF");
    localparam logic [63:0] KW_END  = 64'("END_TEST");

    // Strings arrive right-justified: leading NULs are padding, anything else must be a digit.
    function automatic num_t parse_num(input logic [AW-1:0] s, input logic hex);
        num_t       r;
        logic       started;
        logic       bad;
        logic       dv;
        logic [7:0] c;
        logic [3:0] d;
        r       = '0;
        started = 1'b0;
        bad     = 1'b0;
        for (int i = ARG_CHARS - 1; i >= 0; i--) begin
            c  = s[i*8 +: 8];
            dv = 1'b0;
            d  = 4'd0;
            if (c >= "0" && c <= "9") begin
                dv = 1'b1;
                d  = 4'(c - 8'd48);
            end else if (hex && c >= "a" && c <= "f") begin
                dv = 1'b1;
                d  = 4'(c - 8'd87);
            end else if (hex && c >= "A" && c <= "F") begin
                dv = 1'b1;
                d  = 4'(c - 8'd55);
            end
            if (dv) begin
                started = 1'b1;
                r.val   = hex ? {r.val[27:0], d} : (r.val * 32'd10 + {28'd0, d});
            end else if (c != 8'd0 || started) begin
                bad = 1'b1;
            end
        end
        r.ok = started && !bad;
        return r;
    endfunction

    state_t            state, state_nx;
    kind_t             kind;
    logic [5*AW-1:0]   args_q;
    logic [AW-1:0]     a0, a1, a2, a3, a4;
    num_t              n1, n2;
    logic              dec_err, chk_miss, edge_hit, to_evt, to_q, proto_err, exec_err;
    logic              w_now, w_prev;
    logic [DATA_W-1:0] chk_sel;
    logic [NB_WAIT-1:0] wait_q;
    logic [31:0]       cnt;
    logic [16:0]       err_sum;

    assign a0 = args_q[0*AW +: AW];
    assign a1 = args_q[1*AW +: AW];
    assign a2 = args_q[2*AW +: AW];
    assign a3 = args_q[3*AW +: AW];
    assign a4 = args_q[4*AW +: AW];

    // Decode runs continuously off the latched line, which is stable for the whole command.
    always_comb begin
        n1      = parse_num(a1, 1'b0);
        n2      = parse_num(a2, 1'b1);
        kind    = K_BAD;
        if (a0[AW-1:64] == '0) begin
            case (a0[63:0])
                KW_SET:  kind = K_SET;
                KW_CHK:  kind = K_CHK;
                KW_WCLK: kind = K_WCLK;
                KW_WTR:  kind = K_WTR;
                KW_WTF:  kind = K_WTF;
                KW_END:  kind = K_END;
                default: kind = K_BAD;
            endcase
        end
        // No command takes more than three words; trailing text marks a malformed line.
        dec_err = (a3 != '0) || (a4 != '0);
        case (kind)
            K_SET:         if (!n1.ok || !n2.ok || n1.val >= 32'(NB_SET)) dec_err = 1'b1;
            K_CHK:         if (!n1.ok || !n2.ok || n1.val >= 32'(NB_CHK)) dec_err = 1'b1;
            K_WCLK:        if (!n1.ok) dec_err = 1'b1;
            K_WTR, K_WTF:  if (!n1.ok || n1.val >= 32'(NB_WAIT)) dec_err = 1'b1;
            K_END:         ;
            default:       dec_err = 1'b1;
        endcase
        chk_sel = '0;
        for (int k = 0; k < NB_CHK; k++)
            if (n1.val == 32'(k)) chk_sel = chk_i[k*DATA_W +: DATA_W];
        w_now  = 1'b0;
        w_prev = 1'b0;
        for (int k = 0; k < NB_WAIT; k++)
            if (n1.val == 32'(k)) begin
                w_now  = wait_i[k];
                w_prev = wait_q[k];
            end
        chk_miss  = (kind == K_CHK) && !dec_err && (chk_sel != n2.val[DATA_W-1:0]);
        edge_hit  = (kind == K_WTR) ? (w_now && !w_prev) : (!w_now && w_prev);
        to_evt    = (state == S_WAIT_EDGE) && !edge_hit && (cnt == 32'd1);
        proto_err = args_valid && (state != S_IDLE);
        exec_err  = ((state == S_DECODE) && (dec_err || chk_miss)) || to_evt;
        err_sum   = {1'b0, err_cnt} + {16'd0, proto_err} + {16'd0, exec_err};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (args_valid) state_nx = S_DECODE;
            S_DECODE: begin
                if (dec_err)                              state_nx = S_ACK;
                else if (kind == K_WCLK && n1.val != '0)  state_nx = S_WAIT_CNT;
                else if (kind == K_WTR || kind == K_WTF)  state_nx = S_WAIT_EDGE;
                else                                      state_nx = S_ACK;
            end
            S_WAIT_CNT:  if (cnt == 32'd1) state_nx = S_ACK;
            S_WAIT_EDGE: if (edge_hit || cnt == 32'd1) state_nx = S_ACK;
            S_ACK:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ack       = (state == S_ACK);
        busy      = (state != S_IDLE);
        timeout_o = (state == S_ACK) && to_q;
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            args_q  <= '0;
            set_o   <= '0;
            wait_q  <= '0;
            cnt     <= '0;
            to_q    <= 1'b0;
            err_cnt <= '0;
        end else begin
            wait_q  <= wait_i;
            to_q    <= to_evt;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (state == S_IDLE && args_valid) args_q <= args;
            if (state == S_DECODE) begin
                if (kind == K_WCLK)                       cnt <= n1.val;
                else if (kind == K_WTR || kind == K_WTF)  cnt <= 32'(TIMEOUT_CYCLES);
                if (kind == K_SET && !dec_err)
                    for (int k = 0; k < NB_SET; k++)
                        if (n1.val == 32'(k)) set_o[k*DATA_W +: DATA_W] <= n2.val[DATA_W-1:0];
            end else if (state == S_WAIT_CNT || state == S_WAIT_EDGE) begin
                cnt <= cnt - 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_tb_cmd_executor.sv
// Bench for tb_cmd_executor: vector table of single commands plus hand sequences for
// edge waits, timeouts, busy-time strobes and mid-command reset; acks scored from a queue.
module tb_tb_cmd_executor;
    localparam int AW = 128;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [5*AW-1:0] args = '0;
    logic           args_valid = 1'b0;
    logic           ack, busy, timeout_o;
    logic [255:0]   set_o;
    logic [7:0]     wait_i = '0;
    logic [255:0]   chk_i;
    logic [15:0]    err_cnt;
    logic [2:0]     state_dbg;

    tb_cmd_executor #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .args(args), .args_valid(args_valid), .ack(ack),
        .busy(busy), .set_o(set_o), .wait_i(wait_i), .chk_i(chk_i), .timeout_o(timeout_o),
        .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          bfrom = 1;
    int          bto = 0;
    logic        mon_en = 1'b0;
    logic [15:0] exp_err = '0;
    logic [31:0] set_m [8];
    logic [48:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] set_flat();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = set_m[k];
        return r;
    endfunction

    function automatic logic [AW-1:0] s2a(input string s);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r = {r[AW-9:0], s[i]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string a0, input string a1, input string a2, output int t);
        tick();
        args       = {s2a(""), s2a(""), s2a(a2), s2a(a1), s2a(a0)};
        args_valid = 1'b1;
        t          = cyc;
        tick();
        args_valid = 1'b0;
    endtask

    task automatic expect_ack(input int t, input int lat, input logic to);
        exp_q.push_back({32'(t + lat), exp_err, to});
        bfrom = t + 1;
        bto   = t + lat;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !busy) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL ack_wait: no ack within %0d cycles, %0d still expected", budget, exp_q.size());
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [48:0] e;
            chk("busy", 256'(busy), 256'(rst_n && cyc >= bfrom && cyc <= bto));
            if (ack) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL ack_unexpected: got ack=1 expected no ack (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_cycle", 256'(cyc), 256'(e[48:17]));
                    chk("ack_err_cnt", 256'(err_cnt), 256'(e[16:1]));
                    chk("ack_timeout", 256'(timeout_o), 256'(e[0]));
                    chk("ack_set_o", set_o, set_flat());
                end
            end else if (timeout_o) begin
                chk("timeout_without_ack", 256'(timeout_o), 256'(0));
            end
        end
    end

    typedef struct {
        string       a0, a1, a2;
        int          lat;
        int          err_inc;
        int          set_idx;
        logic [31:0] set_val;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int t;
        vecs[0]  = '{"SET", "2", "A5", 2, 0, 2, 32'h000000A5};
        vecs[1]  = '{"SET", "0", "DEADBEEF", 2, 0, 0, 32'hDEADBEEF};
        vecs[2]  = '{"SET", "7", "ffffffff", 2, 0, 7, 32'hFFFFFFFF};
        vecs[3]  = '{"CHK", "0", "BEEF", 2, 0, -1, 32'h0};
        vecs[4]  = '{"CHK", "0", "DEAD", 2, 1, -1, 32'h0};
        vecs[5]  = '{"CHK", "3", "C0DE0003", 2, 0, -1, 32'h0};
        vecs[6]  = '{"CHK", "3", "c0de0004", 2, 1, -1, 32'h0};
        vecs[7]  = '{"FOO", "", "", 2, 1, -1, 32'h0};
        vecs[8]  = '{"SET", "9", "1", 2, 1, -1, 32'h0};
        vecs[9]  = '{"", "", "", 2, 1, -1, 32'h0};
        vecs[10] = '{"SET", "1", "XYZ", 2, 1, -1, 32'h0};
        vecs[11] = '{"SET", "8", "1", 2, 1, -1, 32'h0};
        vecs[12] = '{"WAIT_CLK", "0", "", 2, 0, -1, 32'h0};
        vecs[13] = '{"WAIT_CLK", "10", "", 12, 0, -1, 32'h0};
        vecs[14] = '{"WAIT_CLK", "1", "", 3, 0, -1, 32'h0};
        vecs[15] = '{"END_TEST", "", "", 2, 0, -1, 32'h0};

        for (int k = 0; k < 8; k++) begin
            set_m[k] = '0;
            chk_i[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
        end
        chk_i[31:0] = 32'h0000BEEF;

        repeat (3) tick();
        chk("reset_ack", 256'(ack), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_set_o", set_o, 256'(0));
        chk("reset_timeout", 256'(timeout_o), 256'(0));
        chk("reset_err_cnt", 256'(err_cnt), 256'(0));
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].a0, vecs[i].a1, vecs[i].a2, t);
            if (vecs[i].err_inc != 0) exp_err = exp_err + 16'd1;
            if (vecs[i].set_idx >= 0) set_m[vecs[i].set_idx] = vecs[i].set_val;
            expect_ack(t, vecs[i].lat, 1'b0);
            wait_idle(100);
        end

        // WTR: rising edge sampled at T+5 -> ack T+6
        send("WTR", "1", "", t);
        expect_ack(t, 6, 1'b0);
        repeat (4) tick();
        wait_i[1] = 1'b1;
        wait_idle(100);
        wait_i[1] = 1'b0;
        tick();

        // WTR: edge only in T+1 is not counted -> timeout at T+52
        send("WTR", "1", "", t);
        wait_i[1] = 1'b1;
        exp_err = exp_err + 16'd1;
        expect_ack(t, 52, 1'b1);
        wait_idle(100);
        wait_i[1] = 1'b0;

        // WTF with wait_i[3] held low -> timeout
        send("WTF", "3", "", t);
        exp_err = exp_err + 16'd1;
        expect_ack(t, 52, 1'b1);
        wait_idle(100);

        // WTF: falling edge at T+2, the earliest counted cycle -> ack T+3
        wait_i[3] = 1'b1;
        tick();
        send("WTF", "3", "", t);
        expect_ack(t, 3, 1'b0);
        tick();
        wait_i[3] = 1'b0;
        wait_idle(100);

        send("WTR", "8", "", t);
        exp_err = exp_err + 16'd1;
        expect_ack(t, 2, 1'b0);
        wait_idle(100);

        // back-to-back: second command accepted the cycle busy drops
        send("SET", "4", "77", t);
        set_m[4] = 32'h77;
        expect_ack(t, 2, 1'b0);
        tick();
        send("SET", "5", "1", t);
        set_m[5] = 32'h1;
        expect_ack(t, 2, 1'b0);
        wait_idle(100);

        // strobe while busy is ignored and counted; ack timing unchanged
        send("WAIT_CLK", "20", "", t);
        exp_err = exp_err + 16'd1;
        expect_ack(t, 22, 1'b0);
        repeat (4) tick();
        args       = {s2a(""), s2a(""), s2a("1"), s2a("0"), s2a("SET")};
        args_valid = 1'b1;
        tick();
        args_valid = 1'b0;
        chk("busy_strobe_err_cnt", 256'(err_cnt), 256'(exp_err));
        wait_idle(100);

        // reset mid-command: outputs clear at once and the ack never comes
        send("WAIT_CLK", "20", "", t);
        expect_ack(t, 22, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        exp_q.delete();
        bfrom   = 1;
        bto     = 0;
        exp_err = '0;
        for (int k = 0; k < 8; k++) set_m[k] = '0;
        #1;
        chk("abort_ack", 256'(ack), 256'(0));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_set_o", set_o, 256'(0));
        chk("abort_timeout", 256'(timeout_o), 256'(0));
        chk("abort_err_cnt", 256'(err_cnt), 256'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (25) tick();

        send("SET", "2", "A5", t);
        set_m[2] = 32'hA5;
        expect_ack(t, 2, 1'b0);
        wait_idle(100);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
